// File: rtl/reaction_fsm.sv
// reaction_fsm: reaction-time game controller. It selects a random delay, times the player's response in ms,
// and reports false starts and timeouts.
module reaction_fsm #(
    parameter int unsigned CLKS_PER_MS = 50000,
    parameter int unsigned TIMEOUT_MS  = 9999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn,
    input  logic        delay_done,
    output logic [3:0]  delay_code,
    output logic        led,
    output logic [15:0] reaction_ms,
    output logic        result_valid,
    output logic        false_start,
    output logic        timeout
);
    localparam int SW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_GO, ST_SHOW} state_t;

    state_t        state_q, state_d;
    logic          btn_s1_q, btn_s2_q, btn_prev_q;
    logic [7:0]    lfsr_q, lfsr_d;
    logic [SW-1:0] sub_q, sub_d;
    logic [15:0]   ms_q, ms_d, ms_nx;
    logic [3:0]    code_q, code_d;
    logic [15:0]   rms_q, rms_d;
    logic          led_q, led_d, rv_q, rv_d, fs_q, fs_d, to_q, to_d;
    logic          press, sub_wrap;

    assign press    = btn_s2_q & ~btn_prev_q;
    assign sub_wrap = sub_q == SW'(CLKS_PER_MS - 1);
    // Completed milliseconds including the one finishing on this edge.
    assign ms_nx    = sub_wrap ? ms_q + 16'd1 : ms_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            btn_s1_q   <= 1'b0;
            btn_s2_q   <= 1'b0;
            btn_prev_q <= 1'b0;
            lfsr_q     <= 8'hA5;
            sub_q      <= '0;
            ms_q       <= '0;
            code_q     <= '0;
            rms_q      <= '0;
            led_q      <= 1'b0;
            rv_q       <= 1'b0;
            fs_q       <= 1'b0;
            to_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            btn_s1_q   <= btn;
            btn_s2_q   <= btn_s1_q;
            btn_prev_q <= btn_s2_q;
            lfsr_q     <= lfsr_d;
            sub_q      <= sub_d;
            ms_q       <= ms_d;
            code_q     <= code_d;
            rms_q      <= rms_d;
            led_q      <= led_d;
            rv_q       <= rv_d;
            fs_q       <= fs_d;
            to_q       <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        sub_d   = sub_q;
        ms_d    = ms_q;
        code_d  = code_q;
        rms_d   = rms_q;
        led_d   = led_q;
        rv_d    = 1'b0;
        fs_d    = fs_q;
        to_d    = to_q;
        case (state_q)
            ST_IDLE: begin
                if (press) begin
                    state_d = ST_WAIT;
                    code_d  = lfsr_q[3:0];
                end
            end
            ST_WAIT: begin
                // A press beats a coincident delay_done.
                if (press) begin
                    state_d = ST_SHOW;
                    rv_d    = 1'b1;
                    fs_d    = 1'b1;
                    to_d    = 1'b0;
                    rms_d   = '0;
                end else if (delay_done) begin
                    state_d = ST_GO;
                    led_d   = 1'b1;
                    sub_d   = '0;
                    ms_d    = '0;
                end
            end
            ST_GO: begin
                sub_d = sub_wrap ? '0 : sub_q + 1'b1;
                ms_d  = ms_nx;
                if (press || ms_nx >= 16'(TIMEOUT_MS)) begin
                    state_d = ST_SHOW;
                    led_d   = 1'b0;
                    rv_d    = 1'b1;
                    fs_d    = 1'b0;
                    to_d    = ~press;
                    rms_d   = press ? ms_nx : 16'(TIMEOUT_MS);
                end
            end
            ST_SHOW: begin
                if (press) begin
                    state_d = ST_WAIT;
                    code_d  = lfsr_q[3:0];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign delay_code   = code_q;
    assign led          = led_q;
    assign reaction_ms  = rms_q;
    assign result_valid = rv_q;
    assign false_start  = fs_q;
    assign timeout      = to_q;
endmodule

// File: tb/tb_reaction_fsm.sv
// tb_reaction_fsm: directed plus randomized scoreboard bench for reaction_fsm.
// The reference model counts GO cycles and replays the LFSR polynomial.
module tb_reaction_fsm;
    localparam int CPM = 4;
    localparam int TO  = 20;

    logic        clk = 1'b0, rst_n = 1'b0, btn = 1'b0, delay_done = 1'b0;
    logic [3:0]  delay_code;
    logic        led, result_valid, false_start, timeout;
    logic [15:0] reaction_ms;

    reaction_fsm #(.CLKS_PER_MS(CPM), .TIMEOUT_MS(TO)) dut (
        .clk(clk), .rst_n(rst_n), .btn(btn), .delay_done(delay_done),
        .delay_code(delay_code), .led(led), .reaction_ms(reaction_ms),
        .result_valid(result_valid), .false_start(false_start), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [15:0] ms; logic fs; logic to; logic [3:0] code;} res_t;
    typedef enum {M_IDLE, M_WAIT, M_GO, M_SHOW} mode_t;

    res_t       exp_q[$];
    int         total = 0, bad = 0, rv_cnt = 0, led_cnt = 0;
    mode_t      m_mode = M_IDLE;
    int         go_n = 0;
    logic [7:0] m_lfsr = 8'hA5;
    logic [3:0] m_dc = 4'd0;
    logic       m_led = 1'b0;
    logic [2:0] hist = 3'd0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tap();
        btn = 1'b1;
        cyc(1);
        btn = 1'b0;
    endtask

    // A press takes effect at edge e when btn was sampled high at e-2 and low at e-3.
    task automatic model_step();
        logic p;
        if (!rst_n) begin
            m_mode = M_IDLE; m_lfsr = 8'hA5; m_dc = 4'd0; m_led = 1'b0; hist = 3'd0; go_n = 0;
            return;
        end
        p = hist[1] & ~hist[2];
        case (m_mode)
            M_IDLE, M_SHOW: if (p) begin m_mode = M_WAIT; m_dc = m_lfsr[3:0]; end
            M_WAIT: begin
                if (p) begin
                    exp_q.push_back('{ms: 16'd0, fs: 1'b1, to: 1'b0, code: m_dc});
                    m_mode = M_SHOW;
                end else if (delay_done) begin
                    m_mode = M_GO; m_led = 1'b1; go_n = 0;
                end
            end
            M_GO: begin
                go_n++;
                if (p || go_n >= CPM * TO) begin
                    exp_q.push_back('{ms: p ? 16'(go_n / CPM) : 16'(TO), fs: 1'b0, to: ~p, code: m_dc});
                    m_mode = M_SHOW; m_led = 1'b0;
                end
            end
            default: ;
        endcase
        m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
        hist = {hist[1:0], btn};
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        res_t e;
        @(negedge clk);
        check("led", led, m_led);
        check("delay_code", delay_code, m_dc);
        if (led) led_cnt++;
        if (result_valid) begin
            rv_cnt++;
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL result_valid: got pulse expected none (no round end pending)");
            end else begin
                e = exp_q.pop_front();
                check("reaction_ms", reaction_ms, e.ms);
                check("false_start", false_start, e.fs);
                check("timeout", timeout, e.to);
                check("code_at_result", delay_code, e.code);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_led"}, led, 0);
        check({tag, "_ms"}, reaction_ms, 0);
        check({tag, "_rv"}, result_valid, 0);
        check({tag, "_fs"}, false_start, 0);
        check({tag, "_to"}, timeout, 0);
        check({tag, "_code"}, delay_code, 0);
    endtask

    task automatic normal_round(input string tag);
        int r0 = rv_cnt;
        tap(); cyc(4);
        delay_done = 1'b1; cyc(1); delay_done = 1'b0;
        cyc(37);
        check({tag, "_led_in_go"}, led, 1);
        btn = 1'b1; cyc(1); btn = 1'b0;
        cyc(5);
        check({tag, "_ms"}, reaction_ms, 10);
        check({tag, "_fs"}, false_start, 0);
        check({tag, "_to"}, timeout, 0);
        check({tag, "_led_after"}, led, 0);
        check({tag, "_pulses"}, rv_cnt - r0, 1);
    endtask

    initial begin
        int r0, l0;
        cyc(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        cyc(2);
        normal_round("normal");
        r0 = rv_cnt;
        tap(); cyc(3); tap(); cyc(4);
        check("fstart_fs", false_start, 1);
        check("fstart_ms", reaction_ms, 0);
        check("fstart_to", timeout, 0);
        check("fstart_led", led, 0);
        check("fstart_pulses", rv_cnt - r0, 1);
        r0 = rv_cnt;
        tap(); cyc(4);
        delay_done = 1'b1; cyc(1); delay_done = 1'b0;
        cyc(90);
        check("tmo_to", timeout, 1);
        check("tmo_ms", reaction_ms, TO);
        check("tmo_fs", false_start, 0);
        check("tmo_led", led, 0);
        check("tmo_pulses", rv_cnt - r0, 1);
        tap(); cyc(3);
        l0 = led_cnt;
        tap(); cyc(1);
        delay_done = 1'b1; cyc(1); delay_done = 1'b0;
        cyc(4);
        check("tie_fs", false_start, 1);
        check("tie_led_cycles", led_cnt - l0, 0);
        tap(); cyc(4);
        delay_done = 1'b1; cyc(1); delay_done = 1'b0;
        cyc(20);
        check("pre_reset_led", led, 1);
        rst_n = 1'b0; cyc(1);
        check_all_zero("midreset");
        rst_n = 1'b1;
        r0 = rv_cnt;
        cyc(5);
        check("midreset_no_pulse", rv_cnt - r0, 0);
        normal_round("after_reset");
        for (int s = 0; s < 6; s++) begin
            int per = $urandom_range(25, 70);
            int gap_max = (s % 3 == 0) ? 20 : (s % 3 == 1) ? 80 : 250;
            int dd_c = 0, hold = 0, gap = 5;
            if (s == 3) begin rst_n = 1'b0; cyc(1); rst_n = 1'b1; end
            repeat (600) begin
                delay_done = (dd_c == 0);
                dd_c = (dd_c + 1) % per;
                if (hold > 0) hold--;
                else if (gap > 0) gap--;
                else begin
                    hold = $urandom_range(1, 4);
                    gap = $urandom_range(1, gap_max);
                end
                btn = (hold > 0);
                cyc(1);
            end
        end
        delay_done = 1'b0; btn = 1'b0;
        cyc(10);
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
